// File: rtl/linear_proj_writeback.sv
// Write-back stage for the linear projection cores: buffers output chunks in a 2-entry
// skid FIFO and writes them to the output BRAM in column-major chunk order.
module linear_proj_writeback #(
  parameter int unsigned WIDTH_OUT      = 16,
  parameter int unsigned BLOCK_SIZE     = 2,
  parameter int unsigned NUM_CORES_A    = 2,
  parameter int unsigned NUM_CORES_B    = 1,
  parameter int unsigned ROW_SIZE_MAT_C = 2,
  parameter int unsigned COL_SIZE_MAT_C = 3,
  parameter int unsigned ADDR_WIDTH     = 8,
  localparam int unsigned MAX_FLAG      = ROW_SIZE_MAT_C * COL_SIZE_MAT_C,
  localparam int unsigned CHUNK_W       = WIDTH_OUT * BLOCK_SIZE * BLOCK_SIZE *
                                          NUM_CORES_A * NUM_CORES_B
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CHUNK_W-1:0]    in_data,
  input  logic                  wr_stall,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [CHUNK_W-1:0]    wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW = $clog2(MAX_FLAG + 1);
  localparam int unsigned RowW = (ROW_SIZE_MAT_C > 1) ? $clog2(ROW_SIZE_MAT_C) : 1;
  localparam int unsigned ColW = (COL_SIZE_MAT_C > 1) ? $clog2(COL_SIZE_MAT_C) : 1;

  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_FLAG);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_FLAG - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(ROW_SIZE_MAT_C - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(COL_SIZE_MAT_C - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]    acc_cnt_q, wr_cnt_q;
  logic [CHUNK_W-1:0] mem_q [2];
  logic               wptr_q, rptr_q;
  logic [1:0]         fcnt_q;
  logic               out_vld_q;
  logic [CHUNK_W-1:0] out_data_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [RowW-1:0]    r_q;
  logic [ColW-1:0]    c_q;

  logic start_ok, push, pop, fifo_full, fifo_empty;

  // start only takes effect outside RUN
  assign start_ok   = start & (state_q != StRun);
  assign fifo_full  = (fcnt_q == 2'd2);
  assign fifo_empty = (fcnt_q == 2'd0);

  assign in_ready = (state_q == StRun) & ~fifo_full & (acc_cnt_q < MaxCnt);
  assign push     = in_valid & in_ready;
  assign wr_en    = out_vld_q & ~wr_stall;
  // Refill the output register when it is empty or its write commits this edge
  assign pop      = ~fifo_empty & (~out_vld_q | wr_en);
  assign wr_data  = out_data_q;
  assign wr_addr  = out_addr_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (wr_en && (wr_cnt_q == LastCnt)) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else if (start_ok) begin
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      if (push)  acc_cnt_q <= acc_cnt_q + CntW'(1);
      if (wr_en) wr_cnt_q  <= wr_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      fcnt_q <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= in_data;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      unique case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 2'd1;
        2'b01:   fcnt_q <= fcnt_q - 2'd1;
        default: ;
      endcase
    end
  end

  // Output register; the chunk's grid position is stamped as it enters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_addr_q <= '0;
      r_q        <= '0;
      c_q        <= '0;
    end else begin
      if (pop) begin
        out_vld_q  <= 1'b1;
        out_data_q <= mem_q[rptr_q];
        out_addr_q <= ADDR_WIDTH'(32'(c_q) * ROW_SIZE_MAT_C + 32'(r_q));
      end else if (wr_en) begin
        out_vld_q <= 1'b0;
      end

      if (start_ok) begin
        r_q <= '0;
        c_q <= '0;
      end else if (pop) begin
        if (c_q == ColLast) begin
          c_q <= '0;
          r_q <= (r_q == RowLast) ? '0 : r_q + RowW'(1);
        end else begin
          c_q <= c_q + ColW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_linear_proj_writeback.sv
// Directed bench for linear_proj_writeback; a negedge monitor pops a scoreboard of
// expected (addr, data) pairs filled as chunks are accepted.
module tb_linear_proj_writeback;

  localparam int unsigned Rows = 2;
  localparam int unsigned Cols = 3;
  localparam int unsigned AW   = 8;
  localparam int unsigned CW   = 128;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, wr_stall, wr_en, busy, done;
  logic [CW-1:0] in_data, wr_data;
  logic [AW-1:0] wr_addr;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   wcyc[$];
  int   checks = 0, failures = 0, cyc = 0;
  int   exp_idx = 0, run_writes = 0, acc0 = -1, first_addr = -1;
  logic last_pending = 1'b0;

  linear_proj_writeback dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .wr_stall (wr_stall),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [CW-1:0] obs, logic [CW-1:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [CW-1:0] mk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (last_pending) begin
        check("done_after_last", done, 1);
        check("busy_after_last", busy, 0);
        last_pending = 1'b0;
      end
      if (start && !busy) begin
        exp_idx = 0; run_writes = 0; acc0 = -1; first_addr = -1;
        wcyc.delete();
      end
      if (wr_en) begin
        check("write_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("wr_addr", wr_addr, mon_e.addr);
          check("wr_data", wr_data, mon_e.data);
        end
        if (run_writes == 0) first_addr = int'(wr_addr);
        run_writes++;
        wcyc.push_back(cyc);
        if (run_writes == Rows * Cols) begin
          check("done_before_last", done, 0);
          last_pending = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        if (acc0 < 0) acc0 = cyc + 1;
        sb.push_back('{addr: AW'((exp_idx % Cols) * Rows + exp_idx / Cols), data: in_data});
        exp_idx++;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer n chunks; optionally stall the BRAM for stall_len cycles after the first accept
  task automatic feed(int n, int stall_len, int start_at, output int rel);
    int   sent = 0, g = 0, st = 0;
    logic acc;
    rel = -1;
    in_valid = 1'b1;
    in_data = mk();
    while (sent < n && g < 100) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; g++;
      start = (g == start_at);
      if (acc) begin sent++; in_data = mk(); end
      if (stall_len > 0 && sent >= 1 && st < stall_len) begin
        wr_stall = 1'b1; st++;
      end else if (wr_stall) begin
        wr_stall = 1'b0; rel = sent;
        #1 check("wr_en_on_release", wr_en, 1);
      end
    end
    start = 1'b0;
    check("feed_accepted", sent, n);
  endtask

  task automatic wait_writes(int n, int budget);
    int g = 0;
    while (run_writes < n && g < budget) begin @(posedge clk); #1; g++; end
    check("wait_writes", run_writes, n);
  endtask

  task automatic wait_done(int budget);
    int g = 0;
    while (!done && g < budget) begin @(posedge clk); #1; g++; end
    check("done_rises", done, 1);
    check("writes_at_done", run_writes, Rows * Cols);
    check("busy_at_done", busy, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic check_gaps();
    check("write_count", wcyc.size(), Rows * Cols);
    for (int i = 1; i < wcyc.size(); i++) check("no_gap", wcyc[i] - wcyc[0], i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; wr_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); rst = 1'b0;

    // Valid before start is ignored
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = mk();
    repeat (3) @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 0);
    check("idle_wr_en", wr_en, 0);
    check("idle_no_write", run_writes, 0);
    in_valid = 1'b0;

    // Basic back-to-back stream, then over-supply
    pulse_start();
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, 1);
    feed(6, 0, -1, rel);
    wait_done(20);
    check_gaps();
    if (wcyc.size() > 0) check("latency", wcyc[0] - acc0, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("oversupply_in_ready", in_ready, 0);
    end
    check("oversupply_writes", run_writes, Rows * Cols);
    in_valid = 1'b0;

    // Restart from DONE with a stall burst and an ignored start mid-run
    pulse_start();
    check("restart_done_clear", done, 0);
    check("restart_busy", busy, 1);
    feed(6, 5, 4, rel);
    in_valid = 1'b0;
    check("stall_inflight", rel, 3);
    wait_done(40);
    check_gaps();

    // Async reset with chunks still queued
    pulse_start();
    feed(5, 0, -1, rel);
    in_valid = 1'b0;
    check("pre_reset_writes", run_writes, 3);
    check("pre_reset_queued", sb.size(), 2);
    #1 rst = 1'b1;
    #1;
    sb.delete();
    check("arst_wr_en", wr_en, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_wr_data", wr_data, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    check("arst_hold_wr_en", wr_en, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", busy, 0);
    pulse_start();
    feed(1, 0, -1, rel);
    in_valid = 1'b0;
    wait_writes(1, 10);
    check("post_reset_first_addr", first_addr, 0);
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_single_write", run_writes, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
